// File: rtl/fp16_pkg.sv
// Shared constants and types for the binary16 multiplier datapath.
// Operand classes and flag bit positions are used by the stage and by tests.
package fp16_pkg;

    localparam int BIAS    = 15;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    // Bit positions inside flags = {nan, inf, zero, uflow}
    localparam int FLAG_NAN   = 3;
    localparam int FLAG_INF   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_UFLOW = 0;

endpackage

// File: rtl/fp16_mul_stage_umul11.sv
// Unsigned combinational multiplier for hidden-bit significands.
// The result is full width, so no product bits are lost here.
module umul11 #(
    parameter int W = 11
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);

    always_comb begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end

endmodule

// File: rtl/fp16_mul_stage.sv
// Two-stage binary16 multiply front end: decode (A), then product, exponent and flags (B).
// The output is unnormalized; a downstream stage normalizes and rounds.
module fp16_mul_stage #(
    parameter int BIAS  = fp16_pkg::BIAS,
    parameter int EXP_W = fp16_pkg::EXP_W,
    parameter int MAN_W = fp16_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   pi,
    output logic [2*MAN_W-1:0]     tm,
    output logic                   sticky,
    output logic [3:0]             flags
);
    import fp16_pkg::*;

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int E_W    = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [E_W-1:0] E_TOP    = E_W'((1 << EXP_W) - 2);
    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
    localparam logic signed [E_W-1:0] E_BIAS   = E_W'(BIAS);

    // Handshake chain
    logic va, vb;
    logic rdy_a, rdy_b;

    assign rdy_b    = !vb || out_ready;
    assign rdy_a    = !va || rdy_b;
    assign in_ready = rdy_a;

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0)
            return ZERO;
        else if (e == EXP_ONES)
            return (f == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

    // Stage A: decode
    logic             sign_a;
    logic [EXP_W-1:0] ea_a, eb_a;
    logic [SIG_W-1:0] ma_a, mb_a;
    fp_class_t        ca_a, cb_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va     <= 1'b0;
            sign_a <= 1'b0;
            ea_a   <= '0;
            eb_a   <= '0;
            ma_a   <= '0;
            mb_a   <= '0;
            ca_a   <= ZERO;
            cb_a   <= ZERO;
        end else if (rdy_a) begin
            va <= in_valid;
            if (in_valid) begin
                sign_a <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                ea_a   <= a[MAN_W +: EXP_W];
                eb_a   <= b[MAN_W +: EXP_W];
                // Subnormals decode as ZERO and carry no significand
                ma_a   <= (a[MAN_W +: EXP_W] != '0) ? {1'b1, a[MAN_W-1:0]} : '0;
                mb_a   <= (b[MAN_W +: EXP_W] != '0) ? {1'b1, b[MAN_W-1:0]} : '0;
                ca_a   <= classify(a[MAN_W +: EXP_W], a[MAN_W-1:0]);
                cb_a   <= classify(b[MAN_W +: EXP_W], b[MAN_W-1:0]);
            end
        end
    end

    // Stage B combinational: product, exponent, special-case override
    logic [PROD_W-1:0]     prod;
    logic signed [E_W-1:0] e_sum;
    logic                  is_nan, is_inf_op, is_zero_op;
    logic [EXP_W-1:0]      n_exp;
    logic [MAN_W-1:0]      n_frac;
    logic [2*MAN_W-1:0]    n_tm;
    logic                  n_sticky;
    logic [3:0]            n_flags;

    umul11 #(.W(SIG_W)) u_umul11 (
        .x (ma_a),
        .y (mb_a),
        .p (prod)
    );

    always_comb begin
        e_sum      = $signed({2'b00, ea_a}) + $signed({2'b00, eb_a}) - E_BIAS;
        is_nan     = (ca_a == NAN) || (cb_a == NAN) ||
                     (ca_a == INF && cb_a == ZERO) || (ca_a == ZERO && cb_a == INF);
        is_inf_op  = (ca_a == INF) || (cb_a == INF);
        is_zero_op = (ca_a == ZERO) || (cb_a == ZERO);

        n_flags  = '0;
        n_exp    = e_sum[EXP_W-1:0];
        n_tm     = prod[PROD_W-1:2];
        n_sticky = |prod[1:0];

        if (is_nan) begin
            n_flags[FLAG_NAN] = 1'b1;
            n_exp             = EXP_ONES;
            n_tm              = '0;
            n_sticky          = 1'b0;
        end else if (is_inf_op) begin
            n_flags[FLAG_INF] = 1'b1;
            n_exp             = EXP_ONES;
            n_tm              = '0;
            n_sticky          = 1'b0;
        end else if (is_zero_op) begin
            n_flags[FLAG_ZERO] = 1'b1;
            n_exp              = '0;
            n_tm               = '0;
            n_sticky           = 1'b0;
        end else if (e_sum > E_TOP) begin
            n_flags[FLAG_INF] = 1'b1;
            n_exp             = EXP_ONES;
            n_tm              = '0;
            n_sticky          = 1'b0;
        end else if (e_sum < E_ONE) begin
            n_flags[FLAG_UFLOW] = 1'b1;
            n_flags[FLAG_ZERO]  = 1'b1;
            n_exp               = '0;
            n_tm                = '0;
            n_sticky            = 1'b0;
        end

        // Fraction field mirrors tm below the two integer bits; quiet bit marks NaN
        n_frac = n_tm[2*MAN_W-3 -: MAN_W];
        if (is_nan)
            n_frac[MAN_W-1] = 1'b1;
    end

    // Stage B register: drives the outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb     <= 1'b0;
            pi     <= '0;
            tm     <= '0;
            sticky <= 1'b0;
            flags  <= '0;
        end else if (rdy_b) begin
            vb <= va;
            if (va) begin
                pi     <= {sign_a, n_exp, n_frac};
                tm     <= n_tm;
                sticky <= n_sticky;
                flags  <= n_flags;
            end
        end
    end

    assign out_valid = vb;

endmodule

// File: tb/tb_fp16_mul_stage.sv
// Self-checking bench for fp16_mul_stage: vector table through a scoreboard,
// plus latency, backpressure and mid-flight reset sequences.
module tb_fp16_mul_stage;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pi;
        logic [19:0] tm;
        logic        st;
        logic [3:0]  fl;
    } vec_t;

    typedef struct packed {
        logic [15:0] pi;
        logic [19:0] tm;
        logic        st;
        logic [3:0]  fl;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] pi;
    logic [19:0] tm;
    logic        sticky;
    logic [3:0]  flags;

    int   n_cmp  = 0;
    int   n_fail = 0;
    res_t sb[$];
    res_t mon_got;
    res_t mon_exp;
    vec_t vecs[18];

    always #5 clk = ~clk;

    fp16_mul_stage #(.BIAS(15), .EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pi        (pi),
        .tm        (tm),
        .sticky    (sticky),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic res_t res_of(input vec_t v);
        return '{pi: v.pi, tm: v.tm, st: v.st, fl: v.fl};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = '{pi: pi, tm: tm, st: sticky, fl: flags};
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %h want none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                check("result", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input res_t ex);
        int w = 0;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 (a=%h b=%h)", va, vb);
        end else begin
            sb.push_back(ex);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 20'h40000, 1'b0, 4'h0};
        vecs[1]  = '{16'h3E00, 16'h3E00, 16'h3D00, 20'h90000, 1'b0, 4'h0};
        vecs[2]  = '{16'h4000, 16'h4200, 16'h4600, 20'h60000, 1'b0, 4'h0};
        vecs[3]  = '{16'h0000, 16'hBC00, 16'h8000, 20'h00000, 1'b0, 4'h2};
        vecs[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 20'h00000, 1'b0, 4'h8};
        vecs[5]  = '{16'h7E00, 16'h3C00, 16'h7E00, 20'h00000, 1'b0, 4'h8};
        vecs[6]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 20'h00000, 1'b0, 4'h4};
        vecs[7]  = '{16'h0400, 16'h0400, 16'h0000, 20'h00000, 1'b0, 4'h3};
        vecs[8]  = '{16'h7C00, 16'hC000, 16'hFC00, 20'h00000, 1'b0, 4'h4};
        vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, 20'h00000, 1'b0, 4'h2};
        vecs[10] = '{16'h3C01, 16'h3C01, 16'h3C02, 20'h40200, 1'b1, 4'h0};
        vecs[11] = '{16'h7800, 16'h3C00, 16'h7800, 20'h40000, 1'b0, 4'h0};
        vecs[12] = '{16'h7800, 16'h4000, 16'h7C00, 20'h00000, 1'b0, 4'h4};
        vecs[13] = '{16'h0400, 16'h3C00, 16'h0400, 20'h40000, 1'b0, 4'h0};
        vecs[14] = '{16'h0400, 16'h3800, 16'h0000, 20'h00000, 1'b0, 4'h3};
        vecs[15] = '{16'hFE00, 16'h3C00, 16'hFE00, 20'h00000, 1'b0, 4'h8};
        vecs[16] = '{16'h3FFF, 16'h3FFF, 16'h3FFC, 20'hFFC00, 1'b1, 4'h0};
        vecs[17] = '{16'h4200, 16'hC200, 16'hC500, 20'h90000, 1'b0, 4'h0};

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pi", 64'(pi), 64'd0);
        check("rst_tm", 64'(tm), 64'd0);
        check("rst_flags", 64'({sticky, flags}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table, back to back
        for (int i = 0; i < 18; i++)
            send(vecs[i].a, vecs[i].b, res_of(vecs[i]));
        drain();

        // Latency: visible two edges after the accepting edge
        @(posedge clk);
        #1;
        send(vecs[0].a, vecs[0].b, res_of(vecs[0]));
        @(negedge clk);
        check("latency_1clk_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_2clk_out_valid", 64'(out_valid), 64'd1);
        drain();

        // Backpressure: both stages fill, third operand waits, outputs hold
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(vecs[0].a, vecs[0].b, res_of(vecs[0]));
        send(vecs[2].a, vecs[2].b, res_of(vecs[2]));
        a        = vecs[6].a;
        b        = vecs[6].b;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_outputs", 64'({pi, tm, sticky, flags}), 64'(res_of(vecs[0])));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[6].a, vecs[6].b, res_of(vecs[6]));
        drain();

        // Reset with both stages full discards in-flight work
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(vecs[1].a, vecs[1].b, res_of(vecs[1]));
        send(vecs[10].a, vecs[10].b, res_of(vecs[10]));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_pi_tm", 64'({pi, tm}), 64'd0);
        check("midrst_flags", 64'({sticky, flags}), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        check("postrst_out_valid", 64'(out_valid), 64'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        send(vecs[16].a, vecs[16].b, res_of(vecs[16]));
        drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
